// File: rtl/wishbone_burst_master.sv
// Wishbone B4 master that runs one command at a time: classic, constant or
// incrementing bursts (linear or wrapping), with bounded retry and error abort.
module wishbone_burst_master #(
    parameter int unsigned WB_ADDR_W = 32,
    parameter int unsigned WB_DATA_W = 32,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    // command port
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WB_ADDR_W-1:0]   cmd_addr,
    input  logic                   cmd_we,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [1:0]             cmd_mode,
    input  logic [1:0]             cmd_bte,
    input  logic [WB_DATA_W/8-1:0] cmd_sel,
    // data and status
    input  logic [WB_DATA_W-1:0]   wr_data,
    output logic                   wr_pop,
    output logic                   rd_valid,
    output logic [WB_DATA_W-1:0]   rd_data,
    output logic                   done,
    output logic                   done_err,
    output logic [LEN_W:0]         beats_done,
    // Wishbone bus
    output logic [WB_ADDR_W-1:0]   ADR_O,
    output logic [WB_DATA_W-1:0]   DAT_O,
    input  logic [WB_DATA_W-1:0]   DAT_I,
    output logic [WB_DATA_W/8-1:0] SEL_O,
    output logic                   WE_O,
    output logic                   STB_O,
    output logic                   CYC_O,
    output logic                   LOCK_O,
    output logic [2:0]             CTI_O,
    output logic [1:0]             BTE_O,
    input  logic                   ACK_I,
    input  logic                   ERR_I,
    input  logic                   RTY_I
);
    localparam int unsigned SEL_W = WB_DATA_W / 8;
    localparam int unsigned STEP  = WB_DATA_W / 8;
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned RTY_W = 4;

    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_INCR  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BUS   = 3'd1,
        S_GAP   = 3'd2,
        S_RETRY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [WB_ADDR_W-1:0]   addr_q;
    logic                   we_q;
    logic [LEN_W-1:0]       len_q;
    logic [1:0]             mode_q;
    logic [1:0]             bte_q;
    logic [SEL_W-1:0]       sel_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [RTY_W-1:0]       rty_q;
    logic                   err_q;
    logic                   rd_valid_q;
    logic [WB_DATA_W-1:0]   rd_data_q;

    logic last_c;
    logic stream_c;
    logic rty_abort_c;

    assign last_c      = (cnt_q == {1'b0, len_q});
    assign stream_c    = (mode_q == MODE_CONST) || (mode_q == MODE_INCR);
    assign rty_abort_c = (rty_q == RTY_W'(MAX_RETRY));

    // Address of the beat after 'a'; wrapping keeps the bits above the wrap span.
    function automatic logic [WB_ADDR_W-1:0] next_addr(
        input logic [WB_ADDR_W-1:0] a,
        input logic [1:0]           mode,
        input logic [1:0]           bte
    );
        logic [WB_ADDR_W-1:0] inc;
        logic [WB_ADDR_W-1:0] mask;
        inc = a + WB_ADDR_W'(STEP);
        unique case (bte)
            2'd1:    mask = WB_ADDR_W'(4 * STEP - 1);
            2'd2:    mask = WB_ADDR_W'(8 * STEP - 1);
            2'd3:    mask = WB_ADDR_W'(16 * STEP - 1);
            default: mask = '0;
        endcase
        if (mode == MODE_CONST)
            return a;
        else if (mode == MODE_INCR && bte != 2'd0)
            return (a & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    // State register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and bus-control decode; ERR beats RTY beats ACK
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        CYC_O     = 1'b0;
        STB_O     = 1'b0;
        LOCK_O    = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_BUS;
            end
            S_BUS: begin
                CYC_O  = 1'b1;
                STB_O  = 1'b1;
                LOCK_O = (len_q != '0);
                if (ERR_I)      state_d = S_DONE;
                else if (RTY_I) state_d = rty_abort_c ? S_DONE : S_RETRY;
                else if (ACK_I) state_d = last_c ? S_DONE : (stream_c ? S_BUS : S_GAP);
            end
            S_GAP: begin
                CYC_O   = 1'b1;
                LOCK_O  = (len_q != '0);
                state_d = S_BUS;
            end
            S_RETRY: begin
                LOCK_O  = (len_q != '0);
                state_d = S_BUS;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, beat/retry counters and read capture
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            len_q      <= '0;
            mode_q     <= 2'd0;
            bte_q      <= 2'd0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rty_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        we_q   <= cmd_we;
                        len_q  <= cmd_len;
                        mode_q <= cmd_mode;
                        bte_q  <= cmd_bte;
                        sel_q  <= cmd_sel;
                        cnt_q  <= '0;
                        rty_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_BUS: begin
                    if (ERR_I) begin
                        err_q <= 1'b1;
                    end else if (RTY_I) begin
                        if (rty_abort_c) err_q <= 1'b1;
                        else             rty_q <= rty_q + RTY_W'(1);
                    end else if (ACK_I) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        rty_q <= '0;
                        if (!we_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= DAT_I;
                        end
                        if (!last_c) addr_q <= next_addr(addr_q, mode_q, bte_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Cycle type: 111 marks the final beat of a const/incr burst
    always_comb begin
        CTI_O = 3'b000;
        if (stream_c)
            CTI_O = last_c ? 3'b111 : ((mode_q == MODE_CONST) ? 3'b001 : 3'b010);
    end

    assign BTE_O      = (mode_q == MODE_INCR) ? bte_q : 2'd0;
    assign ADR_O      = addr_q;
    assign SEL_O      = sel_q;
    assign WE_O       = we_q;
    assign DAT_O      = wr_data;
    assign wr_pop     = STB_O & ACK_I & WE_O & ~ERR_I & ~RTY_I;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign done_err   = done & err_q;
    assign beats_done = cnt_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Randomised scoreboard bench: a transaction-level model predicts each bus
// beat, read word and completion; a monitor compares them as the DUT shows them.
module tb_wishbone_burst_master;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LW   = 8;
    localparam int unsigned MR   = 3;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned STEP = DW / 8;

    localparam int K_ACK = 0;
    localparam int K_RTY = 1;
    localparam int K_ERR = 2;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_we = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic [1:0]    cmd_mode = 2'd0;
    logic [1:0]    cmd_bte = 2'd0;
    logic [SW-1:0] cmd_sel = '0;
    logic [DW-1:0] wr_data;
    logic          wr_pop;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          done_err;
    logic [LW:0]   beats_done;
    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O;
    logic [DW-1:0] DAT_I = '0;
    logic [SW-1:0] SEL_O;
    logic          WE_O, STB_O, CYC_O, LOCK_O;
    logic [2:0]    CTI_O;
    logic [1:0]    BTE_O;
    logic          ACK_I = 1'b0;
    logic          ERR_I = 1'b0;
    logic          RTY_I = 1'b0;

    always #5 CLK_I = ~CLK_I;

    wishbone_burst_master #(.WB_ADDR_W(AW), .WB_DATA_W(DW), .LEN_W(LW), .MAX_RETRY(MR)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
        .cmd_len(cmd_len), .cmd_mode(cmd_mode), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .done_err(done_err), .beats_done(beats_done),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .SEL_O(SEL_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .LOCK_O(LOCK_O), .CTI_O(CTI_O), .BTE_O(BTE_O),
        .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic [1:0]    bte;
        logic          we;
        logic [SW-1:0] sel;
        logic          lock;
        logic          pop;
        logic [2:0]    post;   // {CYC_O, STB_O, done} in the cycle after the response
    } bus_exp_t;

    typedef struct {
        int            kind;
        int            waits;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct {
        logic        err;
        logic [LW:0] beats;
    } done_exp_t;

    bus_exp_t      exp_bus[$];
    logic [DW-1:0] exp_rd[$];
    done_exp_t     exp_done[$];
    resp_t         slave_q[$];
    resp_t         force_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_resp = 1'b0;
    bit   slave_have = 1'b0;
    int   slave_wait = 0;
    resp_t slave_cur;
    bit   post_pending = 1'b0;
    logic [2:0] post_exp = 3'b000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next beat address straight from the addressing rules
    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input logic [1:0] mode,
                                                  input logic [1:0] bte);
        logic [AW-1:0] span;
        logic [AW-1:0] off;
        if (mode == 2'd1) return a;
        if (mode == 2'd2 && bte != 2'd0) begin
            span = AW'((2 << bte) * STEP);
            off  = a % span;
            return (a - off) + ((off + AW'(STEP)) % span);
        end
        return a + AW'(STEP);
    endfunction

    task automatic flush();
        exp_bus.delete();
        exp_rd.delete();
        exp_done.delete();
        slave_q.delete();
        force_q.delete();
        slave_have   = 1'b0;
        post_pending = 1'b0;
    endtask

    // Predict the whole transaction, queue the slave script, then hand over the command
    task automatic issue(input logic [AW-1:0] addr, input logic we, input int len,
                         input logic [1:0] mode, input logic [1:0] bte, input logic [SW-1:0] sel);
        logic [AW-1:0] a = addr;
        int beat = 0;
        int retries = 0;
        bit err = 1'b0;
        bit fin = 1'b0;
        bit streaming = (mode == 2'd1) || (mode == 2'd2);
        int p;
        int n = 0;
        resp_t r;
        bus_exp_t e;
        done_exp_t d;
        while (!fin) begin
            if (force_q.size() != 0) begin
                r = force_q.pop_front();
            end else if (rand_resp) begin
                p = int'($urandom_range(99));
                r.kind  = (p < 80) ? K_ACK : ((p < 94) ? K_RTY : K_ERR);
                r.waits = int'($urandom_range(2));
            end else begin
                r.kind  = K_ACK;
                r.waits = 0;
            end
            r.data = $urandom;
            e.addr = a;
            e.we   = we;
            e.sel  = sel;
            e.lock = (len > 0);
            e.bte  = (mode == 2'd2) ? bte : 2'd0;
            e.cti  = !streaming ? 3'b000 : ((beat == len) ? 3'b111 : ((mode == 2'd1) ? 3'b001 : 3'b010));
            e.pop  = we && (r.kind == K_ACK);
            if (r.kind == K_ERR) begin
                err = 1'b1; fin = 1'b1; e.post = 3'b001;
            end else if (r.kind == K_RTY) begin
                if (retries == int'(MR)) begin
                    err = 1'b1; fin = 1'b1; e.post = 3'b001;
                end else begin
                    retries++; e.post = 3'b000;
                end
            end else begin
                if (!we) exp_rd.push_back(r.data);
                beat++;
                retries = 0;
                if (beat == len + 1) begin
                    fin = 1'b1; e.post = 3'b001;
                end else begin
                    e.post = streaming ? 3'b110 : 3'b100;
                    a = model_next(a, mode, bte);
                end
            end
            exp_bus.push_back(e);
            slave_q.push_back(r);
        end
        d.err   = err;
        d.beats = (LW + 1)'(beat);
        exp_done.push_back(d);

        @(negedge CLK_I);
        while (!cmd_ready && n < 200) begin @(negedge CLK_I); n++; end
        cmd_addr = addr; cmd_we = we; cmd_len = LW'(len);
        cmd_mode = mode; cmd_bte = bte; cmd_sel = sel; cmd_valid = 1'b1;
        @(posedge CLK_I); #1;
        cmd_valid = 1'b0;
        check("accept_cmd_ready", cmd_ready, 1'b0);
        check("accept_cyc_stb", {CYC_O, STB_O}, 2'b11);
        check("accept_addr", ADR_O, addr);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_done.size() != 0 || !cmd_ready) && n < 400) begin @(negedge CLK_I); n++; end
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: command incomplete after %0d cycles, %0d done pending", n, exp_done.size());
            RST_I = 1'b0;
            flush();
            repeat (2) @(negedge CLK_I);
            RST_I = 1'b1;
        end
    endtask

    // Scripted slave: each STB attempt takes the next script entry
    initial begin
        forever begin
            @(negedge CLK_I);
            ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
            if (STB_O === 1'b1 && RST_I) begin
                if (!slave_have && slave_q.size() != 0) begin
                    slave_cur  = slave_q.pop_front();
                    slave_have = 1'b1;
                    slave_wait = slave_cur.waits;
                end
                if (slave_have) begin
                    if (slave_wait == 0) begin
                        DAT_I = slave_cur.data;
                        ACK_I = (slave_cur.kind == K_ACK);
                        RTY_I = (slave_cur.kind == K_RTY);
                        ERR_I = (slave_cur.kind == K_ERR);
                        slave_have = 1'b0;
                    end else begin
                        slave_wait--;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bus_exp_t e;
        done_exp_t d;
        logic [DW-1:0] rdx;
        wr_data = $urandom;
        forever begin
            @(negedge CLK_I); #1;
            if (post_pending) begin
                check("post_cyc_stb_done", {CYC_O, STB_O, done}, post_exp);
                post_pending = 1'b0;
            end
            if (done) begin
                n_cmp++;
                if (exp_done.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding at %0t", $time);
                end else begin
                    n_cmp--;
                    d = exp_done.pop_front();
                    check("done_err", done_err, d.err);
                    check("beats_done", beats_done, d.beats);
                end
            end
            if (rd_valid) begin
                n_cmp++;
                if (exp_rd.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rd_valid: data 0x%0h at %0t", rd_data, $time);
                end else begin
                    n_cmp--;
                    rdx = exp_rd.pop_front();
                    check("rd_data", rd_data, rdx);
                end
            end
            if (STB_O && (ACK_I || ERR_I || RTY_I)) begin
                n_cmp++;
                if (exp_bus.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: addr 0x%0h at %0t", ADR_O, $time);
                end else begin
                    n_cmp--;
                    e = exp_bus.pop_front();
                    check("adr", ADR_O, e.addr);
                    check("cti", CTI_O, e.cti);
                    check("bte", BTE_O, e.bte);
                    check("we", WE_O, e.we);
                    check("sel", SEL_O, e.sel);
                    check("lock", LOCK_O, e.lock);
                    check("wr_pop", wr_pop, e.pop);
                    if (e.we) check("dat_o", DAT_O, wr_data);
                    post_exp     = e.post;
                    post_pending = 1'b1;
                end
            end
            if (wr_pop) wr_data = $urandom;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resp_t r;
        repeat (3) @(negedge CLK_I);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_cyc_stb_lock", {CYC_O, STB_O, LOCK_O}, 3'b000);
        check("rst_done_rd", {done, done_err, rd_valid, wr_pop}, 4'b0000);
        check("rst_adr", ADR_O, '0);
        check("rst_cti_bte", {CTI_O, BTE_O}, 5'b0);
        check("rst_beats", beats_done, '0);
        RST_I = 1'b1;

        rand_resp = 1'b0;
        issue(32'h0000_0100, 1'b0, 3, 2'd2, 2'd0, 4'hF);
        wait_done();
        issue(32'h0000_0108, 1'b1, 3, 2'd2, 2'd1, 4'hF);
        wait_done();
        r.data = '0;
        r.kind = K_ACK; r.waits = 2;
        force_q.push_back(r); force_q.push_back(r);
        issue(32'h0000_0040, 1'b1, 1, 2'd0, 2'd0, 4'h3);
        wait_done();
        r.waits = 0;
        force_q.push_back(r);
        r.kind = K_RTY; force_q.push_back(r); force_q.push_back(r);
        issue(32'h0000_0200, 1'b0, 3, 2'd2, 2'd0, 4'hF);
        wait_done();
        r.kind = K_ACK; force_q.push_back(r);
        r.kind = K_RTY; repeat (4) force_q.push_back(r);
        issue(32'h0000_0300, 1'b1, 3, 2'd2, 2'd2, 4'hC);
        wait_done();
        r.kind = K_ACK; force_q.push_back(r); force_q.push_back(r);
        r.kind = K_ERR; force_q.push_back(r);
        issue(32'h0000_0400, 1'b0, 5, 2'd1, 2'd0, 4'hF);
        wait_done();
        issue(32'hFFFF_FFF8, 1'b0, 3, 2'd2, 2'd0, 4'hF);
        wait_done();

        // Asynchronous reset while beat 1 is waiting on the slave
        r.kind = K_ACK; r.waits = 0; force_q.push_back(r);
        r.waits = 6; force_q.push_back(r);
        issue(32'h0000_0500, 1'b0, 3, 2'd2, 2'd0, 4'hF);
        n = 0;
        while (!(STB_O && ADR_O == 32'h0000_0504) && n < 50) begin @(negedge CLK_I); n++; end
        @(negedge CLK_I); #3;
        RST_I = 1'b0;
        #1;
        check("arst_cyc_stb_lock", {CYC_O, STB_O, LOCK_O}, 3'b000);
        check("arst_cmd_ready", cmd_ready, 1'b1);
        check("arst_done", {done, done_err, rd_valid}, 3'b000);
        check("arst_adr_beats", {ADR_O, beats_done}, '0);
        flush();
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
        issue(32'h0000_0600, 1'b1, 2, 2'd1, 2'd0, 4'hF);
        wait_done();

        rand_resp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue($urandom & 32'hFFFF_FFFC, 1'($urandom), int'($urandom_range(7)),
                  2'($urandom), 2'($urandom), 4'($urandom));
            wait_done();
        end
        repeat (3) @(negedge CLK_I);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_burst_master.md
# wishbone_burst_master

Parametrised Wishbone B4 master engine that executes one command at a time: single or multi-beat reads and writes in classic, constant-address or incrementing-address mode, with linear or 4/8/16-beat wrapping bursts. Compared with the previous generation it adds:

- a valid/ready command port;
- correct per-beat address generation and CTI termination;
- a write-data pop strobe and read-data output;
- bounded RTY_I retry, ERR_I abort, and a completion status.

It sits between a local command source (register block or DMA sequencer) and a Wishbone interconnect.

## Interface
- WB_ADDR_W, 32, byte address width
- WB_DATA_W, 32, data width (8/16/32/64); STEP = WB_DATA_W/8 bytes per beat
- LEN_W, 8, width of cmd_len
- MAX_RETRY, 3, consecutive RTY_I allowed per beat before abort (1..15)

Ports:
- CLK_I  in  1  clock, all logic on rising edge
- RST_I  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high exactly when state = IDLE
- cmd_addr  in  WB_ADDR_W  start byte address, STEP-aligned
- cmd_we  in  1  1 = write, 0 = read
- cmd_len  in  LEN_W  beats minus 1
- cmd_mode  in  2  0 = classic, 1 = const-addr, 2 = incr-addr; 3 treated as classic
- cmd_bte  in  2  0 = linear, 1 = wrap4, 2 = wrap8, 3 = wrap16 (incr mode only)
- cmd_sel  in  WB_DATA_W/8  byte select for every beat
- wr_data  in  WB_DATA_W  current write word, driven straight to DAT_O
- wr_pop  out  1  write beat accepted; source advances next cycle
- rd_valid  out  1  one-cycle read beat strobe
- rd_data  out  WB_DATA_W  registered DAT_I
- done  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done: ERR_I seen or retries exhausted
- beats_done  out  LEN_W+1  ACKed beats of the last command, valid with done
- Wishbone bus: ADR_O out WB_ADDR_W, DAT_O out WB_DATA_W, DAT_I in WB_DATA_W, SEL_O out WB_DATA_W/8, WE_O out 1, STB_O out 1, CYC_O out 1, LOCK_O out 1, CTI_O out 3, BTE_O out 2, ACK_I in 1, ERR_I in 1, RTY_I in 1

## Operation
- **States:** IDLE, BUS, GAP, RETRY, DONE.
- **IDLE:** on cmd_valid, latch all cmd_* fields, clear the beat counter, retry counter and error flag, then go to BUS.
- **BUS:** CYC_O = STB_O = 1; ADR_O, WE_O, SEL_O, CTI_O and BTE_O are driven from registers.
- **ACK_I in BUS:**
  - beat counter increments;
  - write: wr_pop = 1 in the same cycle (combinational from STB_O & ACK_I & WE_O);
  - read: rd_data <= DAT_I and rd_valid pulses next cycle;
  - retry counter clears.
  - Last beat (count = len): go to DONE.
  - Classic mode: go to GAP.
  - Otherwise stay in BUS with the next address.
- **GAP (classic only):** STB_O = 0, CYC_O = 1 for one cycle, then BUS.
- **ERR_I in BUS:** set the error flag and go to DONE.
- **RTY_I in BUS:**
  - If retry count = MAX_RETRY: error, go to DONE.
  - Otherwise increment the retry count and go to RETRY.
- **RETRY:** CYC_O = STB_O = 0 for one cycle, then BUS with the same address and beat.
- **Priority:** ERR_I > RTY_I > ACK_I when asserted together.
- **DONE:** CYC_O = STB_O = 0, done = 1, done_err = error flag; next state is IDLE.
- **Address, const mode:** unchanged.
- **Address, classic and incr linear:** addr + STEP, modulo 2^WB_ADDR_W.
- **Address, incr wrapN:** bits above log2(N·STEP) are fixed; the low field becomes (low + STEP) mod (N·STEP). The burst ends after len+1 beats regardless of N.
- **CTI_O:**
  - classic: 000;
  - const: 001;
  - incr: 010;
  - 111 on the final beat of const/incr.
- **BTE_O:** latched cmd_bte in incr mode, else 00.
- **LOCK_O:** 1 from the first BUS cycle through RETRY/GAP until DONE when len > 0; else 0.
- **Out-of-state qualifiers:** ACK/ERR/RTY outside BUS are ignored.

## Timing
- **Reset values:** all outputs 0 except cmd_ready = 1. State goes to IDLE immediately on RST_I low, including mid-burst (CYC_O drops asynchronously). Counters are cleared and no done pulse is generated.
- **Command start:** command accepted at edge T; ADR_O/CYC_O/STB_O are valid in the cycle after T. cmd_ready = 0 from that cycle until IDLE returns.
- **Zero-wait incr/const burst:** len+1 consecutive STB cycles; next beat address is presented in the cycle after each ACK.
- **Classic:** 2 cycles per beat minimum.
- **done:** asserted in the cycle after the final ACK/ERR/RTY-abort; cmd_ready returns 1 the cycle after that.
- **Back-to-back commands:** minimum 2 idle bus cycles between commands.
- **rd_valid:** exactly one per read ACK, one cycle later; never on ERR or RTY.

## Test plan
- Incr linear read, addr 0x100, len 3, zero-wait ACK:
  - ADR_O 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles;
  - CTI_O 010, 010, 010, 111;
  - 4 rd_valid;
  - done with beats_done 4, done_err 0.
- Incr wrap4 write, addr 0x108, len 3:
  - ADR_O 0x108, 0x10C, 0x100, 0x104;
  - BTE_O 01;
  - 4 wr_pop pulses, DAT_O tracks wr_data.
- Classic write, len 1, ACK after 2 waits per beat:
  - STB_O low one cycle between beats, CYC_O stays high;
  - CTI_O 000;
  - LOCK_O high throughout.
- RTY_I on beat 1 twice with MAX_RETRY 3:
  - two 1-cycle CYC drops;
  - beat 1 re-addressed identically;
  - done_err 0.
- RTY_I four times on the same beat:
  - abort; done_err 1, beats_done 1.
- ERR_I on beat 2 of a const-mode read (len 5):
  - done_err 1, beats_done 2;
  - no rd_valid for beat 2.
- Reset during beat 1:
  - outputs go to reset values asynchronously, no done pulse;
  - after reset, a new command is accepted normally.
